// File: rtl/cam_ctrl.sv
// cam_ctrl: single-outstanding request sequencer in front of a CAM search/write core.
// Each request searches for SEARCH_LAT cycles; an INSERT miss adds one WRITE cycle before the response.
module cam_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int SEARCH_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  cam_start,
  output logic                  cam_we,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [ADDR_WIDTH-1:0] cam_waddr,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  full,
  output logic [1:0]            dbg_state
);

  localparam int LAT_W = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SEARCH_LAT - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_WRITE = 2'd2, S_RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic                  live_q;
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  accept;
  logic                  last;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and response fields stay stable while rsp_valid && !rsp_ready.
  assign accept = req_valid && req_ready;
  assign last   = (lat_q == LAT_LAST);
  assign full   = (cnt_q == DEPTH_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_SEARCH;
      S_SEARCH: if (last) state_d = (cam_match || !op_q || full) ? S_RESP : S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = live_q && (state_q == S_IDLE);
    cam_start   = (state_q == S_SEARCH);
    cam_we      = (state_q == S_WRITE);
    cam_din     = (state_q == S_SEARCH || state_q == S_WRITE) ? key_q : '0;
    cam_waddr   = (state_q == S_WRITE) ? cnt_q[ADDR_WIDTH-1:0] : '0;
    rsp_valid   = (state_q == S_RESP);
    rsp_hit     = hit_q;
    rsp_err     = err_q;
    rsp_addr    = addr_q;
    entry_count = cnt_q;
    dbg_state   = state_q;
  end

  // Request/response datapath; the match result is taken only on the final search cycle.
  always_comb begin
    op_d   = op_q;
    key_d  = key_q;
    lat_d  = lat_q;
    cnt_d  = cnt_q;
    hit_d  = hit_q;
    err_d  = err_q;
    addr_d = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = req_op;
          key_d  = req_key;
          lat_d  = '0;
          hit_d  = 1'b0;
          err_d  = 1'b0;
          addr_d = '0;
        end
      end
      S_SEARCH: begin
        if (!last) begin
          lat_d = lat_q + 1'b1;
        end else begin
          hit_d  = cam_match;
          addr_d = cam_match ? cam_match_addr : '0;
          err_d  = !cam_match && op_q && full;
        end
      end
      S_WRITE: begin
        addr_d = cnt_q[ADDR_WIDTH-1:0];
        if (!full) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 1'b0;
      key_q  <= '0;
      lat_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      op_q   <= op_d;
      key_q  <= key_d;
      lat_q  <= lat_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      err_q  <= err_d;
      addr_q <= addr_d;
    end
  end

endmodule
